// File: rtl/digital_clock_param.sv
// Purpose : HH:MM:SS time-of-day counter with prescaler, 12/24h display, validated load, nested rollover ticks.
// Latency : counters and tick pulses update on the rising edge after the prescaler tick cycle; display mapping is combinational.
// Backpr. : none; en=0 freezes the prescaler and counters, and a valid load always wins over counting.
//
// Ports:
//   Clk_1sec            clock, CLK_DIV cycles per second
//   reset               asynchronous active-low reset
//   en                  count enable (prescaler and counters)
//   mode_12h            0 = 24-hour display, 1 = 12-hour display
//   load_en             one-cycle load request for load_sec/load_min/load_hr (24h format)
//   seconds/minutes     current time fields
//   hours, pm           displayed hour (0-23 or 1-12) and afternoon flag
//   sec/min/hour/day_tick  single-cycle rollover pulses, aligned with the updated time
//   load_err            one-cycle pulse after a rejected (out-of-range) load
//
// Optional alarm (define DIGITAL_CLOCK_ALARM_EN):
//   alarm_set, alarm_min, alarm_hr  capture and arm an alarm time (HH:MM:00)
//   alarm_clr                       clear the alarm indication, stay armed
//   alarm_out                       sticky alarm indication

module digital_clock_param #(
  parameter int CLK_DIV = 1,
  // Derived width of the prescaler counter; leave at its default.
  parameter int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
  input  logic       Clk_1sec,
  input  logic       reset,
  input  logic       en,
  input  logic       mode_12h,
  input  logic       load_en,
  input  logic [5:0] load_sec,
  input  logic [5:0] load_min,
  input  logic [4:0] load_hr,
`ifdef DIGITAL_CLOCK_ALARM_EN
  input  logic       alarm_set,
  input  logic [5:0] alarm_min,
  input  logic [4:0] alarm_hr,
  input  logic       alarm_clr,
  output logic       alarm_out,
`endif
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic       pm,
  output logic       sec_tick,
  output logic       min_tick,
  output logic       hour_tick,
  output logic       day_tick,
  output logic       load_err
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [4:0] HR_MAX  = 5'd23;
  localparam logic [4:0] HR_NOON = 5'd12;

  // --------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------
  logic [DIV_W-1:0] div_q, div_d;
  logic [5:0]       sec_q, sec_d;
  logic [5:0]       min_q, min_d;
  logic [4:0]       hr_q,  hr_d;
  logic             sec_tick_q,  sec_tick_d;
  logic             min_tick_q,  min_tick_d;
  logic             hour_tick_q, hour_tick_d;
  logic             day_tick_q,  day_tick_d;
  logic             load_err_q,  load_err_d;

  // --------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------
  logic tick_due;
  logic load_ok;
  logic load_take;
  logic sec_wrap;
  logic min_wrap;
  logic hr_wrap;

  always_comb begin
    tick_due  = en && (div_q == DIV_LAST);
    load_ok   = (load_sec <= SEC_MAX) && (load_min <= MIN_MAX) && (load_hr <= HR_MAX);
    load_take = load_en && load_ok;
    sec_wrap  = (sec_q == SEC_MAX);
    min_wrap  = (min_q == MIN_MAX);
    hr_wrap   = (hr_q  == HR_MAX);
  end

  // --------------------------------------------------------------------
  // Next-state: load has priority over counting; a taken load also
  // swallows a tick that was due in the same cycle and restarts the second.
  // --------------------------------------------------------------------
  always_comb begin
    div_d       = div_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hr_d        = hr_q;
    sec_tick_d  = 1'b0;
    min_tick_d  = 1'b0;
    hour_tick_d = 1'b0;
    day_tick_d  = 1'b0;
    load_err_d  = 1'b0;

    if (load_take) begin
      sec_d = load_sec;
      min_d = load_min;
      hr_d  = load_hr;
      div_d = '0;
    end else begin
      // A rejected load is reported but otherwise invisible to counting.
      load_err_d = load_en;

      if (en) begin
        if (tick_due) begin
          div_d = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      if (tick_due) begin
        sec_tick_d = 1'b1;
        if (sec_wrap) begin
          sec_d      = '0;
          min_tick_d = 1'b1;
          if (min_wrap) begin
            min_d       = '0;
            hour_tick_d = 1'b1;
            if (hr_wrap) begin
              hr_d       = '0;
              day_tick_d = 1'b1;
            end else begin
              hr_d = hr_q + 1'b1;
            end
          end else begin
            min_d = min_q + 1'b1;
          end
        end else begin
          sec_d = sec_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk_1sec or negedge reset) begin
    if (!reset) begin
      div_q       <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hr_q        <= '0;
      sec_tick_q  <= 1'b0;
      min_tick_q  <= 1'b0;
      hour_tick_q <= 1'b0;
      day_tick_q  <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hr_q        <= hr_d;
      sec_tick_q  <= sec_tick_d;
      min_tick_q  <= min_tick_d;
      hour_tick_q <= hour_tick_d;
      day_tick_q  <= day_tick_d;
      load_err_q  <= load_err_d;
    end
  end

  // --------------------------------------------------------------------
  // Display mapping: internal hour is always 24h; only the view changes,
  // so toggling mode_12h never disturbs the time.
  // --------------------------------------------------------------------
  always_comb begin
    hours = hr_q;
    if (mode_12h) begin
      if (hr_q == '0) begin
        hours = HR_NOON;
      end else if (hr_q > HR_NOON) begin
        hours = hr_q - HR_NOON;
      end else begin
        hours = hr_q;
      end
    end
  end

  assign pm        = (hr_q >= HR_NOON);
  assign seconds   = sec_q;
  assign minutes   = min_q;
  assign sec_tick  = sec_tick_q;
  assign min_tick  = min_tick_q;
  assign hour_tick = hour_tick_q;
  assign day_tick  = day_tick_q;
  assign load_err  = load_err_q;

`ifdef DIGITAL_CLOCK_ALARM_EN
  // --------------------------------------------------------------------
  // Alarm: matches only on a counting tick landing on HH:MM:00; a load that
  // jumps onto the alarm time does not fire it.
  // --------------------------------------------------------------------
  logic [5:0] al_min_q, al_min_d;
  logic [4:0] al_hr_q,  al_hr_d;
  logic       armed_q,  armed_d;
  logic       al_out_q, al_out_d;
  logic       al_hit;

  always_comb begin
    al_min_d = al_min_q;
    al_hr_d  = al_hr_q;
    armed_d  = armed_q;
    al_out_d = al_out_q;

    al_hit = armed_q && tick_due && !load_take &&
             (sec_d == '0) && (min_d == al_min_q) && (hr_d == al_hr_q);

    if (alarm_set && (alarm_min <= MIN_MAX) && (alarm_hr <= HR_MAX)) begin
      al_min_d = alarm_min;
      al_hr_d  = alarm_hr;
      armed_d  = 1'b1;
    end

    // Clear beats a simultaneous match.
    if (alarm_clr) begin
      al_out_d = 1'b0;
    end else if (al_hit) begin
      al_out_d = 1'b1;
    end
  end

  always_ff @(posedge Clk_1sec or negedge reset) begin
    if (!reset) begin
      al_min_q <= '0;
      al_hr_q  <= '0;
      armed_q  <= 1'b0;
      al_out_q <= 1'b0;
    end else begin
      al_min_q <= al_min_d;
      al_hr_q  <= al_hr_d;
      armed_q  <= armed_d;
      al_out_q <= al_out_d;
    end
  end

  assign alarm_out = al_out_q;
`endif

endmodule

// File: tb/tb_digital_clock_param.sv
// Purpose : self-checking bench for digital_clock_param (CLK_DIV=4).
// Latency : compares one time unit after each rising edge.
// Backpr. : n/a.
module tb_digital_clock_param;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       mode_12h;
  logic       load_en;
  logic [5:0] load_sec;
  logic [5:0] load_min;
  logic [4:0] load_hr;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       pm;
  logic       sec_tick;
  logic       min_tick;
  logic       hour_tick;
  logic       day_tick;
  logic       load_err;
`ifdef DIGITAL_CLOCK_ALARM_EN
  logic       alarm_set;
  logic [5:0] alarm_min;
  logic [4:0] alarm_hr;
  logic       alarm_clr;
  logic       alarm_out;
`endif

  always #5 clk = ~clk;

  digital_clock_param #(.CLK_DIV(CLK_DIV)) dut (
    .Clk_1sec (clk),
    .reset    (reset),
    .en       (en),
    .mode_12h (mode_12h),
    .load_en  (load_en),
    .load_sec (load_sec),
    .load_min (load_min),
    .load_hr  (load_hr),
`ifdef DIGITAL_CLOCK_ALARM_EN
    .alarm_set(alarm_set),
    .alarm_min(alarm_min),
    .alarm_hr (alarm_hr),
    .alarm_clr(alarm_clr),
    .alarm_out(alarm_out),
`endif
    .seconds  (seconds),
    .minutes  (minutes),
    .hours    (hours),
    .pm       (pm),
    .sec_tick (sec_tick),
    .min_tick (min_tick),
    .hour_tick(hour_tick),
    .day_tick (day_tick),
    .load_err (load_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: time as seconds since midnight, prescaler as an int.
  int m_secs;
  int m_pre;
  bit m_st, m_mt, m_ht, m_dt, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_secs = 0; m_pre = 0;
    m_st = 0; m_mt = 0; m_ht = 0; m_dt = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit tick;
    bit valid;
    tick  = en && (m_pre == CLK_DIV - 1);
    valid = (load_sec < 60) && (load_min < 60) && (load_hr < 24);
    m_st = 0; m_mt = 0; m_ht = 0; m_dt = 0;
    m_err = 0;
    if (load_en && valid) begin
      m_secs = int'(load_hr) * 3600 + int'(load_min) * 60 + int'(load_sec);
      m_pre  = 0;
    end else begin
      m_err = load_en;
      if (en) m_pre = tick ? 0 : m_pre + 1;
      if (tick) begin
        m_secs = (m_secs + 1) % 86400;
        m_st = 1;
        m_mt = (m_secs % 60) == 0;
        m_ht = (m_secs % 3600) == 0;
        m_dt = (m_secs == 0);
      end
    end
  endtask

  task automatic check_model();
    int h;
    int disp;
    h    = m_secs / 3600;
    disp = mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
    chk("seconds",   seconds,   m_secs % 60);
    chk("minutes",   minutes,   (m_secs / 60) % 60);
    chk("hours",     hours,     disp);
    chk("pm",        pm,        h >= 12);
    chk("sec_tick",  sec_tick,  m_st);
    chk("min_tick",  min_tick,  m_mt);
    chk("hour_tick", hour_tick, m_ht);
    chk("day_tick",  day_tick,  m_dt);
    chk("load_err",  load_err,  m_err);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_step();
    #1;
    check_model();
  endtask

  typedef struct {
    logic [5:0] ls;
    logic [5:0] lm;
    logic [4:0] lh;
    logic       md;
    logic [5:0] es;
    logic [5:0] em;
    logic [4:0] eh;
    logic       ep;
    logic       ee;
  } vec_t;

  vec_t tbl[11];
  int   tick_cnt;

  initial begin
    // Load table, applied with en=0; state carries from row to row.
    tbl[0]  = '{6'd0,  6'd30, 5'd0,  1'b1, 6'd0,  6'd30, 5'd12, 1'b0, 1'b0};
    tbl[1]  = '{6'd0,  6'd0,  5'd13, 1'b1, 6'd0,  6'd0,  5'd1,  1'b1, 1'b0};
    tbl[2]  = '{6'd0,  6'd0,  5'd13, 1'b0, 6'd0,  6'd0,  5'd13, 1'b1, 1'b0};
    tbl[3]  = '{6'd60, 6'd5,  5'd5,  1'b0, 6'd0,  6'd0,  5'd13, 1'b1, 1'b1};
    tbl[4]  = '{6'd0,  6'd5,  5'd24, 1'b0, 6'd0,  6'd0,  5'd13, 1'b1, 1'b1};
    tbl[5]  = '{6'd0,  6'd60, 5'd0,  1'b0, 6'd0,  6'd0,  5'd13, 1'b1, 1'b1};
    tbl[6]  = '{6'd59, 6'd59, 5'd23, 1'b1, 6'd59, 6'd59, 5'd11, 1'b1, 1'b0};
    tbl[7]  = '{6'd0,  6'd0,  5'd12, 1'b1, 6'd0,  6'd0,  5'd12, 1'b1, 1'b0};
    tbl[8]  = '{6'd0,  6'd0,  5'd0,  1'b0, 6'd0,  6'd0,  5'd0,  1'b0, 1'b0};
    tbl[9]  = '{6'd63, 6'd63, 5'd31, 1'b1, 6'd0,  6'd0,  5'd12, 1'b0, 1'b1};
    tbl[10] = '{6'd7,  6'd8,  5'd9,  1'b1, 6'd7,  6'd8,  5'd9,  1'b0, 1'b0};

    reset = 1'b1; en = 1'b0; mode_12h = 1'b0; load_en = 1'b0;
    load_sec = '0; load_min = '0; load_hr = '0;
`ifdef DIGITAL_CLOCK_ALARM_EN
    alarm_set = 1'b0; alarm_min = '0; alarm_hr = '0; alarm_clr = 1'b0;
`endif
    model_reset();

    // Reset for 3 cycles, then free-run 40 cycles.
    #2 reset = 1'b0;
    repeat (3) cycle();
    reset = 1'b1;
    en    = 1'b1;
    tick_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (sec_tick) tick_cnt++;
      chk("tick_phase", sec_tick, ((i + 1) % 4) == 0);
    end
    chk("run40_seconds", seconds, 10);
    chk("run40_ticks", tick_cnt, 10);

    // Table of loads with counting frozen.
    en = 1'b0;
    for (int i = 0; i < 11; i++) begin
      load_sec = tbl[i].ls; load_min = tbl[i].lm; load_hr = tbl[i].lh;
      mode_12h = tbl[i].md; load_en = 1'b1;
      cycle();
      chk("tbl_sec",  seconds,  tbl[i].es);
      chk("tbl_min",  minutes,  tbl[i].em);
      chk("tbl_hr",   hours,    tbl[i].eh);
      chk("tbl_pm",   pm,       tbl[i].ep);
      chk("tbl_err",  load_err, tbl[i].ee);
      load_en = 1'b0;
      cycle();
      chk("tbl_err_pulse", load_err, 0);
    end

    // Day rollover from 23:59:58.
    mode_12h = 1'b0; en = 1'b1;
    load_sec = 6'd58; load_min = 6'd59; load_hr = 5'd23; load_en = 1'b1;
    cycle();
    load_en = 1'b0;
    repeat (8) cycle();
    chk("day_sec", seconds, 0);
    chk("day_min", minutes, 0);
    chk("day_hr",  hours,   0);
    chk("day_ticks", {sec_tick, min_tick, hour_tick, day_tick}, 4'b1111);

    // Freeze in mid-prescale, then resume.
    load_sec = 6'd0; load_min = 6'd0; load_hr = 5'd0; load_en = 1'b1;
    cycle();
    load_en = 1'b0;
    repeat (2) cycle();
    en = 1'b0;
    repeat (20) begin
      cycle();
      chk("frozen_sec", seconds, 0);
      chk("frozen_tick", sec_tick, 0);
    end
    en = 1'b1;
    cycle();
    chk("resume_early", sec_tick, 0);
    cycle();
    chk("resume_tick", sec_tick, 1);
    chk("resume_sec", seconds, 1);

    // Asynchronous reset between edges.
    #2 reset = 1'b0;
    #1;
    chk("async_sec",  seconds,  0);
    chk("async_tick", sec_tick, 0);
    chk("async_all",  {minutes, hours, pm, min_tick, hour_tick, day_tick, load_err}, 0);
    model_reset();
    cycle();
    reset = 1'b1;

    // Randomised traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      en       = ($urandom_range(0, 7) != 0);
      mode_12h = $urandom_range(0, 1);
      load_en  = ($urandom_range(0, 15) == 0);
      load_sec = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(54, 59));
      load_min = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(58, 59));
      load_hr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(22, 23));
      cycle();
    end
    load_en = 1'b0;

`ifdef DIGITAL_CLOCK_ALARM_EN
    en = 1'b1; mode_12h = 1'b0;
    alarm_set = 1'b1; alarm_min = 6'd0; alarm_hr = 5'd7;
    cycle();
    alarm_set = 1'b0;
    load_sec = 6'd58; load_min = 6'd59; load_hr = 5'd6; load_en = 1'b1;
    cycle();
    load_en = 1'b0;
    repeat (7) cycle();
    chk("alarm_early", alarm_out, 0);
    cycle();
    chk("alarm_hr", hours, 7);
    chk("alarm_fire", alarm_out, 1);
    repeat (8) cycle();
    chk("alarm_hold", alarm_out, 1);
    alarm_clr = 1'b1;
    cycle();
    alarm_clr = 1'b0;
    chk("alarm_clr", alarm_out, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/digital_clock_param.md
Name: digital_clock_param

Overview:
Parametrised successor to the current Digital_Clock. Keeps the HH:MM:SS counter chain and adds:
- a prescaler, so the block runs from a faster clock;
- runtime 12/24-hour display mode;
- validated time load;
- clock-enable;
- single-cycle rollover ticks for downstream logic such as displays and calendars.

Time is always held internally as 24-hour values. Only the displayed hours change with mode.

Parameters:
CLK_DIV, 1, input clock cycles per one-second tick; must be >= 1; 1 gives the legacy 1 Hz behaviour
DIV_W, $clog2(CLK_DIV) with a minimum of 1, width of the prescaler counter; derived, do not override

Ports:
Clk_1sec  in  1  clock; runs at CLK_DIV Hz
reset  in  1  asynchronous, active-low reset (0 = reset)
en  in  1  count enable; low freezes the prescaler and all counters
mode_12h  in  1  0 = 24-hour display, 1 = 12-hour display
load_en  in  1  one-cycle request to load the time fields
load_sec  in  6  seconds to load, 0-59
load_min  in  6  minutes to load, 0-59
load_hr  in  5  hours to load, 24-hour format, 0-23
seconds  out  6  current seconds, 0-59
minutes  out  6  current minutes, 0-59
hours  out  5  displayed hours: 0-23, or 1-12 in 12-hour mode
pm  out  1  1 when internal hour >= 12; valid in both modes
sec_tick  out  1  one-cycle pulse on every seconds increment
min_tick  out  1  one-cycle pulse on the seconds 59->0 wrap
hour_tick  out  1  one-cycle pulse on the minutes 59->0 wrap
day_tick  out  1  one-cycle pulse on the 23:59:59->00:00:00 wrap
load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset is asynchronous and active-low. While asserted: prescaler=0, sec=min=hr=0, all tick outputs=0, load_err=0.
- Reset output values: hours=0 in 24-hour mode, hours=12 in 12-hour mode; pm=0.
- Release of reset is synchronous to the next rising edge.
- Prescaler counts 0..CLK_DIV-1 while en=1. The internal one-second tick fires on the cycle where count==CLK_DIV-1; the prescaler then returns to 0.
- With CLK_DIV=1, every enabled cycle is a tick.
- All registered outputs update on the rising edge after the tick cycle. Tick pulses are registered and coincide with the updated counter values.
- Increment chain on a tick:
  - sec+1;
  - sec 59->0 carries to min;
  - min 59->0 carries to hr;
  - hr 23->0 raises day_tick.
- Ticks are nested: a day rollover pulses sec_tick, min_tick, hour_tick and day_tick on the same cycle.
- en=0: prescaler and counters hold and no ticks are generated. The prescaler count is preserved and resumes where it stopped.
- Load request (load_en=1):
  - Valid when load_sec<=59, load_min<=59 and load_hr<=23. The fields are written on that edge and the prescaler clears to 0. No tick pulses are generated that cycle, even if a tick was due.
  - Invalid when any field is out of range. The time is unchanged, the prescaler continues normally (a due tick still happens), and load_err pulses the following cycle.
  - Load takes priority over en; loading is permitted while en=0.
- Display mapping:
  - 24-hour mode: hours equals the internal hour.
  - 12-hour mode: internal 0->12, 1..12 unchanged, 13..23->1..11.
  - The mapping is combinational from the internal register and mode_12h, so a mode change takes effect in the same cycle with no time change.
- Illegal internal states cannot be reached; only validated loads write the counters.

Optional Feature:
Macro DIGITAL_CLOCK_ALARM_EN.
- When defined, adds these ports:
  - alarm_set (in, 1): captures the alarm time.
  - alarm_min (in, 6) and alarm_hr (in, 5): alarm time to capture.
  - alarm_clr (in, 1): clears the alarm.
  - alarm_out (out, 1): alarm indication.
- alarm_set with alarm_min<=59 and alarm_hr<=23 captures the alarm time and arms the alarm. Out-of-range values are ignored.
- When armed and a tick makes the time equal alarm_hr:alarm_min:00, alarm_out sets on that edge and stays high until alarm_clr.
- alarm_clr clears alarm_out and keeps the alarm armed. If alarm_clr and a match occur in the same cycle, the clear wins.
- Reset clears the alarm time, the armed flag and alarm_out.
- When the macro is not defined, the ports and logic are absent and the block otherwise behaves identically.

Test Plan:
- CLK_DIV=4; reset low for 3 cycles, then high; run 40 cycles -> seconds=10, sec_tick every 4th cycle, all other outputs 0.
- Load 23:59:58, en=1 -> after 8 cycles the time is 00:00:00, with sec_tick, min_tick, hour_tick and day_tick all high on the same cycle.
- Load sec=60 (min=5, hr=5) -> time unchanged and load_err high for exactly 1 cycle. Then load hr=24 -> same result.
- Load 00:30:00, mode_12h=1 -> hours=12, pm=0. Load 13:00:00 -> hours=1, pm=1. Set mode_12h=0 -> hours=13 with no time change.
- en=0 for 20 cycles in mid-prescale (count=2) -> no change. Set en=1 -> next tick 2 cycles later. Assert reset mid-count -> all outputs 0 immediately, without waiting for a clock edge.
- With DIGITAL_CLOCK_ALARM_EN: alarm 07:00, load 06:59:58 -> alarm_out rises at 07:00:00 and holds; alarm_clr -> alarm_out=0.
